// File: rtl/sha256_msg_arbiter.sv
// Two-requester front end for a single SHA-256 core. A multi-block message holds
// the core until its last block; a small tag FIFO routes each digest back to its owner.
module sha256_msg_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [511:0] req0_block,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [511:0] req1_block,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic         res0_valid,
  output logic [255:0] res0_hash,
  output logic         res1_valid,
  output logic [255:0] res1_hash,
  output logic [511:0] core_block_in,
  output logic         core_valid_in,
  output logic         core_is_last,
  input  logic         core_pause,
  input  logic [255:0] core_hash_out,
  input  logic         core_valid_out,
  output logic         busy,
  output logic         err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                r_state, w_stateNext;
  logic                  r_rrPtr, w_rrNext;
  logic [CW-1:0]         r_tagCount;
  logic [PW-1:0]         r_wrPtr, r_rdPtr;
  logic [TAG_DEPTH-1:0]  r_tagOwner;
  logic                  r_coreValid, r_coreIsLast;
  logic [511:0]          r_coreBlock;
  logic                  r_res0Valid, r_res1Valid, r_err;
  logic [255:0]          r_res0Hash, r_res1Hash;

  logic w_holdoff, w_canIssue, w_grantValid, w_grant;
  logic w_ready0, w_ready1, w_acc0, w_acc1, w_accept, w_accLast;
  logic w_push, w_pop, w_popOwner;
  logic [511:0] w_accBlock;

  // A non-final block needs one spare cycle in the core before the next block.
  assign w_holdoff    = r_coreValid && !r_coreIsLast;
  assign w_canIssue   = !core_pause && !w_holdoff && (r_tagCount < DEPTH_C);
  assign w_grantValid = req0_valid || req1_valid;
  assign w_grant      = (req0_valid && req1_valid) ? r_rrPtr : req1_valid;

  assign w_ready0 = !rst && w_canIssue &&
                    ((r_state == LOCK0) || ((r_state == IDLE) && w_grantValid && !w_grant));
  assign w_ready1 = !rst && w_canIssue &&
                    ((r_state == LOCK1) || ((r_state == IDLE) && w_grantValid && w_grant));

  assign w_acc0     = req0_valid && w_ready0;
  assign w_acc1     = req1_valid && w_ready1;
  assign w_accept   = w_acc0 || w_acc1;
  assign w_accLast  = w_acc1 ? req1_last  : req0_last;
  assign w_accBlock = w_acc1 ? req1_block : req0_block;
  assign w_push     = w_accept && w_accLast;
  assign w_pop      = core_valid_out && (r_tagCount != '0);
  assign w_popOwner = r_tagOwner[r_rdPtr];

  always_comb begin
    w_stateNext = r_state;
    w_rrNext    = r_rrPtr;
    if (w_acc0) begin
      w_stateNext = req0_last ? IDLE : LOCK0;
      if (req0_last) w_rrNext = 1'b1;
    end else if (w_acc1) begin
      w_stateNext = req1_last ? IDLE : LOCK1;
      if (req1_last) w_rrNext = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rrPtr <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_rrPtr <= w_rrNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coreValid  <= 1'b0;
      r_coreIsLast <= 1'b0;
      r_coreBlock  <= '0;
    end else begin
      r_coreValid  <= w_accept;
      r_coreIsLast <= w_accept && w_accLast;
      if (w_accept) r_coreBlock <= w_accBlock;
    end
  end

  // Owner FIFO: one entry per message in flight, popped in issue order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tagOwner <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_tagCount <= '0;
    end else begin
      if (w_push) begin
        r_tagOwner[r_wrPtr] <= w_acc1;
        r_wrPtr             <= r_wrPtr + PW'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
      if (w_push && !w_pop)      r_tagCount <= r_tagCount + CW'(1);
      else if (!w_push && w_pop) r_tagCount <= r_tagCount - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res0Valid <= 1'b0;
      r_res1Valid <= 1'b0;
      r_res0Hash  <= '0;
      r_res1Hash  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_res0Valid <= w_pop && !w_popOwner;
      r_res1Valid <= w_pop && w_popOwner;
      if (w_pop && !w_popOwner) r_res0Hash <= core_hash_out;
      if (w_pop && w_popOwner)  r_res1Hash <= core_hash_out;
      if (core_valid_out && (r_tagCount == '0)) r_err <= 1'b1;
    end
  end

  assign req0_ready    = w_ready0;
  assign req1_ready    = w_ready1;
  assign core_valid_in = r_coreValid;
  assign core_is_last  = r_coreIsLast;
  assign core_block_in = r_coreBlock;
  assign res0_valid    = r_res0Valid;
  assign res1_valid    = r_res1Valid;
  assign res0_hash     = r_res0Hash;
  assign res1_hash     = r_res1Hash;
  assign busy          = (r_state != IDLE) || (r_tagCount != '0);
  assign err           = r_err;

endmodule

// File: doc/sha256_msg_arbiter.md
SHA256_MSG_ARBITER -- requirements
Module: sha256_msg_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4: maximum number of messages issued to the core whose hash is still outstanding (power of 2, 2..16).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester offers a block.
REQ-006 SHALL have ports req0_block / req1_block  in  512  padded message block.
REQ-007 SHALL have ports req0_last / req1_last  in  1  block is the final block of its message.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  block accepted at this rising edge when valid && ready.
REQ-009 SHALL have ports res0_valid / res1_valid  out  1  one-cycle pulse: hash for that requester.
REQ-010 SHALL have ports res0_hash / res1_hash  out  256  digest, held until the next pulse on that port.
REQ-011 SHALL have port core_block_in  out  512  block to the SHA-256 core.
REQ-012 SHALL have port core_valid_in  out  1  one-cycle block strobe to the core.
REQ-013 SHALL have port core_is_last  out  1  qualifies core_valid_in.
REQ-014 SHALL have port core_pause  in  1  core cannot take a block.
REQ-015 SHALL have ports core_hash_out  in  256  and core_valid_out  in  1  core digest and strobe.
REQ-016 SHALL have ports busy  out  1  (lock held or tags outstanding) and err  out  1  (sticky protocol error).

Function
REQ-017 can_issue SHALL be !core_pause && !holdoff && (tag_count < TAG_DEPTH).
REQ-018 State machine SHALL be IDLE, LOCK0, LOCK1; reqN_ready = can_issue && (state==LOCKN || (IDLE && grant==N)).
REQ-019 In IDLE, grant SHALL go to the sole valid requester; with both valid it SHALL go to rr_ptr; with none valid, no grant.
REQ-020 Accepted block with last=0 SHALL move to LOCKN (or stay there); in LOCKN the other requester SHALL get ready=0.
REQ-021 Accepted block with last=1 SHALL return to IDLE, set rr_ptr to the other requester, and push owner ID N into the tag FIFO.
REQ-022 Accepted block SHALL appear on core_block_in/core_is_last with core_valid_in=1 exactly one cycle after the accepting edge (registered); otherwise core_valid_in=0.
REQ-023 holdoff SHALL be 1 for the single cycle in which core_valid_in=1 with core_is_last=0; back-to-back last=1 blocks SHALL be issued on consecutive cycles.
REQ-024 On core_valid_out=1 the tag FIFO SHALL pop; on the next cycle resK_valid=1 and resK_hash=core_hash_out for popped owner K; the other port SHALL be unchanged.
REQ-025 Simultaneous push and pop SHALL leave tag_count unchanged; push when full cannot occur (ready=0).
REQ-026 core_valid_out with an empty FIFO SHALL be discarded and set err=1 until reset.
REQ-027 tag_count SHALL be $clog2(TAG_DEPTH)+1 bits; FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-028 Hashes SHALL be routed strictly in message-issue order.

Reset
REQ-029 While rst=1: state=IDLE, rr_ptr=0, holdoff=0, tag_count=0, FIFO pointers 0, all ready/valid/strobe outputs 0, core_block_in=0, res hashes=0, busy=0, err=0.
REQ-030 Reset mid-message or with tags outstanding SHALL abandon the lock and all tags; no result pulse SHALL follow for pre-reset messages.

Verification
REQ-031 req0 single block "abc" (0x616263800...0018, last=1) -> core_valid_in one cycle later; res0_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; res1_valid never set.
REQ-032 req0 and req1 valid same cycle from reset, each one-block (abc / empty 0x80...0) -> req0 first, req1 next cycle; res0=ba7816bf..., res1=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-033 req1 two-block 448-bit message "abcdbcde...nopq" while req0 streams abc -> req0_ready=0 between req1 blocks; res1_hash=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-034 core_pause held 1 for 20 cycles with both requesters valid -> both ready=0, no core_valid_in; issue resumes the cycle after pause drops.
REQ-035 TAG_DEPTH=4, 5 last=1 blocks offered with core stalled -> 4 accepted, 5th held until first core_valid_out; then 5 results in order.
REQ-036 core_valid_out pulse after reset with no issue -> err=1, no res pulse; rst asserted mid two-block message -> all outputs at reset values, busy=0.
